// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin arbiter for the register-file write port
//
// Shares one register-file write port between NREQ writeback requesters.
// Each cycle at most one valid request is granted. The grant goes to the
// first valid requester at or after the round-robin pointer. The accepted
// write is registered and appears on o_rf_* as a single-cycle pulse one
// cycle later.
//
// Optional feature macro: RF_WB_FWD_EN
//   When defined, this block also compares the committing write against two
//   read addresses, so that readers can bypass the register file.
//
// Ports:
//   i_clk          clock; all state changes on the rising edge
//   i_resetn       asynchronous active-low reset
//   i_flush        synchronous flush: no grant, and the write stage is cleared
//   i_req_valid    per-requester write request            [NREQ]
//   o_req_ready    per-requester grant, one-hot or zero   [NREQ]
//   i_req_rd       destination registers, k at [k*AW +: AW]
//   i_req_data     write data, k at [k*XLEN +: XLEN]
//   o_rf_we        registered write enable
//   o_rf_rd        registered destination register
//   o_rf_data      registered write data
//   i_fwd_rs1/2    forwarding compare addresses           (RF_WB_FWD_EN)
//   o_fwd_rs1/2_hit  committing write matches rs1/rs2     (RF_WB_FWD_EN)
//   o_fwd_data     data of the committing write           (RF_WB_FWD_EN)
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_flush,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*AW-1:0]   i_req_rd,
    input  logic [NREQ*XLEN-1:0] i_req_data,
    output logic                 o_rf_we,
    output logic [AW-1:0]        o_rf_rd,
    output logic [XLEN-1:0]      o_rf_data
`ifdef RF_WB_FWD_EN
    ,
    input  logic [AW-1:0]        i_fwd_rs1,
    input  logic [AW-1:0]        i_fwd_rs2,
    output logic                 o_fwd_rs1_hit,
    output logic                 o_fwd_rs2_hit,
    output logic [XLEN-1:0]      o_fwd_data
`endif
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;

    logic            rf_we_q,   rf_we_d;
    logic [AW-1:0]   rf_rd_q,   rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic [PW-1:0]   rr_ptr_q,  rr_ptr_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [PW1-1:0]  cand;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    // Search upward from rr_ptr with wrap at NREQ. The wrap uses one extra bit,
    // so NREQ values that are not powers of two wrap correctly.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + PW1'(i);
            if (cand >= PW1'(NREQ)) begin
                cand = cand - PW1'(NREQ);
            end
            if (!gnt_found && i_req_valid[cand[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PW-1:0];
            end
        end
        // A flush suppresses the grant. The pointer is therefore left untouched.
        if (i_flush) begin
            gnt_found = 1'b0;
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (gnt_found) begin
            o_req_ready = NREQ'(1) << gnt_idx;
        end
    end

    assign sel_rd   = i_req_rd[int'(gnt_idx)*AW +: AW];
    assign sel_data = i_req_data[int'(gnt_idx)*XLEN +: XLEN];

    // The write enable is a one-cycle pulse. Address and data hold when idle.
    // A write to x0 is accepted, but it is never enabled.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        rr_ptr_d  = rr_ptr_q;
        if (gnt_found) begin
            rf_rd_d   = sel_rd;
            rf_data_d = sel_data;
            rf_we_d   = (sel_rd != '0);
            rr_ptr_d  = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign o_rf_we   = rf_we_q;
    assign o_rf_rd   = rf_rd_q;
    assign o_rf_data = rf_data_q;

`ifdef RF_WB_FWD_EN
    // The compare is gated by the write enable. As a result, x0 never hits.
    assign o_fwd_rs1_hit = rf_we_q && (rf_rd_q == i_fwd_rs1);
    assign o_fwd_rs2_hit = rf_we_q && (rf_rd_q == i_fwd_rs2);
    assign o_fwd_data    = rf_data_q;
`endif

endmodule
